// File: rtl/hazard_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEM_WAIT = 2'b01,
    HALT     = 2'b10
  } hz_state_t;

  // Bubble loaded by the pipeline registers on flush (addi x0, x0, 0).
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// Saturating up-counter: counts inc pulses, sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Hazard controller: stage enables/flushes for load-use, branch and
// memory-wait hazards, plus memory watchdog and stall/flush counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       IFID_rs1,
  input  logic [4:0]       IFID_rs2,
  input  logic             IFID_uses_rs2,
  input  logic [4:0]       IDEX_rd,
  input  logic             IDEX_MemRead,
  input  logic             branch_taken,
  input  logic             EXMEM_MemReq,
  input  logic             mem_ready,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IDEX_Write,
  output logic             EXMEM_Write,
  output logic             MEMWB_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Flush,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             timeout_err
);

  localparam int unsigned WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  hz_state_t         state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic              freeze, branch_flush, load_use;

  always_comb begin
    state_nxt = state;
    freeze    = 1'b0;
    case (state)
      RUN: begin
        if (EXMEM_MemReq && !mem_ready) begin
          freeze    = 1'b1;
          state_nxt = MEM_WAIT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = RUN;
        end else begin
          freeze = 1'b1;
          if (wait_cnt == WAIT_LAST) state_nxt = HALT;
        end
      end
      HALT: begin
        freeze = 1'b1;
      end
      default: begin
        state_nxt = RUN;
      end
    endcase

    branch_flush = !freeze && branch_taken;
    load_use     = !freeze && !branch_taken && IDEX_MemRead && (IDEX_rd != 5'd0) &&
                   ((IDEX_rd == IFID_rs1) || (IFID_uses_rs2 && (IDEX_rd == IFID_rs2)));
  end

  // Reset overrides the hazard logic so bubbles flow while PC holds.
  always_comb begin
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IDEX_Write  = 1'b1;
    EXMEM_Write = 1'b1;
    MEMWB_Write = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Flush  = 1'b0;
    if (reset) begin
      PC_Write   = 1'b0;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (freeze) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IDEX_Write  = 1'b0;
      EXMEM_Write = 1'b0;
      MEMWB_Write = 1'b0;
    end else if (branch_flush) begin
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end else if (load_use) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= (state == MEM_WAIT) ? wait_cnt + 1'b1 : '0;
      if ((state == MEM_WAIT) && (state_nxt == HALT)) timeout_err <= 1'b1;
    end
  end

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (freeze || load_use),
    .count (stall_cnt)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (branch_flush),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: driver queues hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_hazard_ctrl_unit;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] IFID_rs1, IFID_rs2, IDEX_rd;
  logic       IFID_uses_rs2, IDEX_MemRead, branch_taken, EXMEM_MemReq, mem_ready;
  logic       PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write;
  logic       IFID_Flush, IDEX_Flush, timeout_err;
  logic [3:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_ctrl_unit #(.TIMEOUT(8), .CNT_W(4)) dut (
    .clk           (clk),
    .reset         (reset),
    .IFID_rs1      (IFID_rs1),
    .IFID_rs2      (IFID_rs2),
    .IFID_uses_rs2 (IFID_uses_rs2),
    .IDEX_rd       (IDEX_rd),
    .IDEX_MemRead  (IDEX_MemRead),
    .branch_taken  (branch_taken),
    .EXMEM_MemReq  (EXMEM_MemReq),
    .mem_ready     (mem_ready),
    .PC_Write      (PC_Write),
    .IFID_Write    (IFID_Write),
    .IDEX_Write    (IDEX_Write),
    .EXMEM_Write   (EXMEM_Write),
    .MEMWB_Write   (MEMWB_Write),
    .IFID_Flush    (IFID_Flush),
    .IDEX_Flush    (IDEX_Flush),
    .stall_cnt     (stall_cnt),
    .flush_cnt     (flush_cnt),
    .timeout_err   (timeout_err)
  );

  // Enables are {PC, IFID, IDEX, EXMEM, MEMWB}; flushes are {IFID, IDEX}.
  localparam logic [4:0] EN_ALL = 5'b11111;
  localparam logic [4:0] EN_FRZ = 5'b00000;
  localparam logic [4:0] EN_LU  = 5'b00111;
  localparam logic [4:0] EN_RST = 5'b01111;
  localparam logic [1:0] FL_NO  = 2'b00;
  localparam logic [1:0] FL_ID  = 2'b01;
  localparam logic [1:0] FL_ALL = 2'b11;

  typedef struct {
    string      tag;
    logic [4:0] en;
    logic [1:0] fl;
    int         sc;
    int         fc;
    logic       te;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input string tag, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s [%s] actual=%0d required=%0d", name, tag, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("enables", mon_e.tag,
          int'({PC_Write, IFID_Write, IDEX_Write, EXMEM_Write, MEMWB_Write}), int'(mon_e.en));
      chk("flushes", mon_e.tag, int'({IFID_Flush, IDEX_Flush}), int'(mon_e.fl));
      chk("stall_cnt", mon_e.tag, int'(stall_cnt), mon_e.sc);
      chk("flush_cnt", mon_e.tag, int'(flush_cnt), mon_e.fc);
      chk("timeout_err", mon_e.tag, int'(timeout_err), int'(mon_e.te));
    end
  end

  task automatic vec(input string tag, input logic r,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic mr, input logic br,
                     input logic req, input logic rdy,
                     input logic [4:0] en, input logic [1:0] fl,
                     input int sc, input int fc, input logic te);
    exp_t e;
    reset         = r;
    IFID_rs1      = rs1;
    IFID_rs2      = rs2;
    IFID_uses_rs2 = u2;
    IDEX_rd       = rd;
    IDEX_MemRead  = mr;
    branch_taken  = br;
    EXMEM_MemReq  = req;
    mem_ready     = rdy;
    e.tag = tag; e.en = en; e.fl = fl; e.sc = sc; e.fc = fc; e.te = te;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    IFID_rs1 = '0; IFID_rs2 = '0; IFID_uses_rs2 = 1'b0; IDEX_rd = '0;
    IDEX_MemRead = 1'b0; branch_taken = 1'b0; EXMEM_MemReq = 1'b0; mem_ready = 1'b0;
    @(posedge clk);
    #1;

    // Reset and load-use / no-dependency cases
    vec("rst0",      1, 0, 0, 0, 0, 0, 0, 0, 0, EN_RST, FL_ALL, 0, 0, 0);
    vec("rst1",      1, 0, 0, 0, 0, 0, 0, 0, 0, EN_RST, FL_ALL, 0, 0, 0);
    vec("lu_rs1",    0, 5, 0, 0, 5, 1, 0, 0, 0, EN_LU,  FL_ID,  0, 0, 0);
    vec("lu_after",  0, 5, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  1, 0, 0);
    vec("rd_x0",     0, 0, 0, 1, 0, 1, 0, 0, 0, EN_ALL, FL_NO,  1, 0, 0);
    vec("rs2_unused",0, 3, 7, 0, 7, 1, 0, 0, 0, EN_ALL, FL_NO,  1, 0, 0);
    vec("lu_rs2",    0, 3, 7, 1, 7, 1, 0, 0, 0, EN_LU,  FL_ID,  1, 0, 0);
    vec("normal",    0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  2, 0, 0);
    vec("br_over_lu",0, 5, 0, 0, 5, 1, 1, 0, 0, EN_ALL, FL_ALL, 2, 0, 0);
    vec("br_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  2, 1, 0);

    // Memory wait: ready 3 cycles after the request, then same-cycle ready
    vec("mw_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, EN_RST, FL_ALL, 2, 1, 0);
    vec("mw_run",    0, 0, 0, 0, 0, 0, 0, 1, 0, EN_FRZ, FL_NO,  0, 0, 0);
    vec("mw_w0",     0, 0, 0, 0, 0, 0, 0, 1, 0, EN_FRZ, FL_NO,  1, 0, 0);
    vec("mw_w1",     0, 0, 0, 0, 0, 0, 0, 1, 0, EN_FRZ, FL_NO,  2, 0, 0);
    vec("mw_ready",  0, 0, 0, 0, 0, 0, 0, 1, 1, EN_ALL, FL_NO,  3, 0, 0);
    vec("mw_back",   0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  3, 0, 0);
    vec("mw_same",   0, 0, 0, 0, 0, 0, 0, 1, 1, EN_ALL, FL_NO,  3, 0, 0);
    vec("mw_nowait", 0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  3, 0, 0);

    // Taken branch held through a 2-cycle memory wait
    vec("bf_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, EN_RST, FL_ALL, 3, 0, 0);
    vec("bf_frz0",   0, 0, 0, 0, 0, 0, 1, 1, 0, EN_FRZ, FL_NO,  0, 0, 0);
    vec("bf_frz1",   0, 0, 0, 0, 0, 0, 1, 1, 0, EN_FRZ, FL_NO,  1, 0, 0);
    vec("bf_release",0, 0, 0, 0, 0, 0, 1, 1, 1, EN_ALL, FL_ALL, 2, 0, 0);
    vec("bf_after",  0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  2, 1, 0);

    // Watchdog: RUN freeze cycle, 8 MEM_WAIT cycles, then HALT
    vec("wd_rst",    1, 0, 0, 0, 0, 0, 0, 0, 0, EN_RST, FL_ALL, 2, 1, 0);
    vec("wd_run",    0, 0, 0, 0, 0, 0, 0, 1, 0, EN_FRZ, FL_NO,  0, 0, 0);
    for (int i = 0; i < 8; i++)
      vec("wd_wait", 0, 0, 0, 0, 0, 0, 0, 1, 0, EN_FRZ, FL_NO,  i + 1, 0, 0);
    vec("wd_halt",   0, 0, 0, 0, 0, 0, 0, 1, 0, EN_FRZ, FL_NO,  9, 0, 1);
    vec("wd_hold_rdy",0,0, 0, 0, 0, 0, 1, 0, 1, EN_FRZ, FL_NO, 10, 0, 1);
    vec("wd_hold_lu",0, 5, 0, 0, 5, 1, 0, 0, 0, EN_FRZ, FL_NO, 11, 0, 1);
    vec("wd_reset",  1, 0, 0, 0, 0, 0, 0, 0, 0, EN_RST, FL_ALL,12, 0, 1);
    vec("wd_cleared",0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO,  0, 0, 0);

    // Saturation: 20 consecutive load-use cycles on a 4-bit counter
    for (int i = 0; i < 20; i++)
      vec("sat_lu",  0, 5, 0, 0, 5, 1, 0, 0, 0, EN_LU,  FL_ID, (i < 15) ? i : 15, 0, 0);
    vec("sat_hold",  0, 0, 0, 0, 0, 0, 0, 0, 0, EN_ALL, FL_NO, 15, 0, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Pipeline hazard controller for the 5-stage RV32 core. It sequences the IF/ID/EX/MEM/WB pipeline registers by generating the per-stage write enables and flushes. It does this for three cases: load-use stalls, taken-branch flushes, and variable-latency data-memory waits. It sits beside the operand-forwarding logic and covers the hazards that forwarding cannot resolve. It also owns the memory-wait watchdog and the stall/flush performance counters.

## Interface
- `TIMEOUT`, default 64: maximum consecutive MEM_WAIT cycles before the block halts.
- `CNT_W`, default 16: width of the performance counters.

- `clk`  in  1  core clock.
- `reset`  in  1  synchronous, active-high reset. The block has one clock.
- `IFID_rs1`, `IFID_rs2`  in  5 each  source registers of the instruction in ID.
- `IFID_uses_rs2`  in  1  the ID instruction reads rs2. Low for I-type, load, LUI and JAL.
- `IDEX_rd`  in  5  destination register of the instruction in EX.
- `IDEX_MemRead`  in  1  the EX instruction is a load.
- `branch_taken`  in  1  the branch or jump in EX resolves as taken.
- `EXMEM_MemReq`  in  1  the MEM-stage instruction is accessing data memory.
- `mem_ready`  in  1  data memory completes the access this cycle.
- `PC_Write`, `IFID_Write`, `IDEX_Write`, `EXMEM_Write`, `MEMWB_Write`  out  1 each  stage register enables.
- `IFID_Flush`, `IDEX_Flush`  out  1 each  load a NOP bubble into that register.
- `stall_cnt`, `flush_cnt`  out  `CNT_W` each  saturating performance counters.
- `timeout_err`  out  1  sticky flag: the memory watchdog has expired.

## Operation
- The FSM has three states, encoded `RUN`=00, `MEM_WAIT`=01, `HALT`=10.
- Stage enables and flushes are combinational from the current state and the inputs. The state, counters and `timeout_err` are registered.
- **Freeze.** It applies in `MEM_WAIT` when `mem_ready` is 0, in `RUN` when `EXMEM_MemReq` is 1 and `mem_ready` is 0, and always in `HALT`.
  - All five stage enables are 0 and both flushes are 0.
- **Branch flush.** It applies when there is no freeze and `branch_taken` is 1.
  - `IFID_Flush`=1 and `IDEX_Flush`=1.
  - All enables are 1.
- **Load-use stall.** It applies when there is no freeze, no branch flush, `IDEX_MemRead` is 1 and `IDEX_rd` is not 0. In addition, `IDEX_rd` must equal `IFID_rs1`, or must equal `IFID_rs2` with `IFID_uses_rs2` high.
  - `PC_Write`=0, `IFID_Write`=0 and `IDEX_Flush`=1.
  - `IDEX_Write`, `EXMEM_Write` and `MEMWB_Write` are 1.
- **Normal.** All enables are 1 and both flushes are 0.
- **Priority:** freeze, then branch flush, then load-use. Consequences:
  - A branch held during a freeze flushes in the release cycle.
  - A load-use hazard coinciding with a taken branch is discarded by the flush.
- **Transitions:**
  - `RUN` goes to `MEM_WAIT` when `EXMEM_MemReq` is 1 and `mem_ready` is 0.
  - `MEM_WAIT` goes to `RUN` on `mem_ready`=1. That cycle is unfrozen.
  - `MEM_WAIT` goes to `HALT` when the wait counter reaches `TIMEOUT`-1 with `mem_ready`=0.
  - `HALT` is left only by `reset`.
- **Wait counter** (internal, clog2(`TIMEOUT`) bits): cleared on entering `MEM_WAIT`, incremented each cycle in `MEM_WAIT`.
- **Performance counters:**
  - `stall_cnt` increments on every freeze or load-use cycle.
  - `flush_cnt` increments on every branch-flush cycle.
  - Both saturate at all-ones and never wrap.
- `timeout_err` is set on entry to `HALT` and cleared only by `reset`.

## Timing
- Hazard response has zero-cycle latency: enables and flushes react in the same cycle as the inputs.
- A load-use stall lasts exactly 1 cycle. The next cycle the load has left EX and the hazard deasserts naturally.
- With a memory request, the pipeline is frozen for N cycles when `mem_ready` arrives N cycles after `EXMEM_MemReq` rises.
  - `mem_ready` in the same cycle as the request gives 0 freeze cycles and no state change.
- While `reset` is high:
  - `PC_Write`=0, the other four enables are 1, and both flushes are 1, so bubbles propagate.
  - State returns to `RUN`; counters and `timeout_err` go to 0.
- Reset in the middle of `MEM_WAIT` or `HALT` takes effect on the next edge. There is no carry-over.

## Structure
- Package `hazard_pkg` holds:
  - the state typedef `hz_state_t` (`RUN`/`MEM_WAIT`/`HALT`);
  - the NOP encoding constant `NOP_INSTR` = 32'h00000013, used by the pipeline registers on flush.
- Sub-module `sat_counter`, parameterised by width, with inputs `clk`, `reset` and `inc`. It is instantiated twice, for `stall_cnt` and `flush_cnt`.

## Test plan
- **Load-use:** `IDEX_MemRead`=1, `IDEX_rd`=5, `IFID_rs1`=5. Required: one cycle of `PC_Write`=0, `IFID_Write`=0, `IDEX_Flush`=1; then `stall_cnt`=1.
- **Dependency on x0 or unused rs2:** `IDEX_rd`=0 gives no stall. `IDEX_rd`=7 with `IFID_rs2`=7 and `IFID_uses_rs2`=0 gives no stall.
- **Memory wait:** `EXMEM_MemReq`=1, with `mem_ready` arriving after 3 cycles. Required: 3 frozen cycles, state `MEM_WAIT`, then `RUN`; `stall_cnt`=3.
- **Branch during freeze:** `branch_taken`=1 held through a 2-cycle memory wait. Required: flushes stay 0 while frozen and pulse in the release cycle; `flush_cnt`=1.
- **Watchdog:** `TIMEOUT`=8, `mem_ready` held at 0. Required: `HALT` after 8 wait cycles, `timeout_err`=1, permanent freeze until `reset`.
- **Saturation:** `CNT_W`=4 with 20 stall cycles. Required: `stall_cnt` holds at 15.
